alarm_rtc: RTL and testbench
============================

Name: alarm_rtc

Overview:
- Avalon-MM slave peripheral that sits directly downstream of the NIOS interval timer.
- Consumes the timer's one-cycle timeout_pulse (1 Hz at 50 MHz with the default 50,000,000-cycle period) as its tick input.
- Maintains hh:mm:ss time of day and an hh:mm alarm.
- Drives a ring output plus a CPU interrupt, with snooze and dismiss controls, for the alarm-clock SoC.

Parameters:
- TICK_DIV, 1, number of tick pulses per second advance (1..255).
- RING_SECS, 60, seconds the alarm rings before auto-stop (1..4095).
- SNOOZE_MIN, 5, snooze length in minutes (1..60).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle pulse from the interval timer's timeout_pulse
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- readdata  out  16  registered read data
- irq  out  1  alarm interrupt
- ring  out  1  high while the alarm is ringing (buzzer/LED)
- sec_pulse  out  1  one-cycle pulse on each second advance

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All state updates on posedge clk.
- Reset values:
  - readdata=0, irq=0, ring=0, sec_pulse=0.
  - Time 00:00:00; alarm 00:00; control=0; flag=0; state IDLE; tick divider=0.
- Write: wr = chipselect & ~write_n.
- Register map:
  - 0 STATUS: read {14'b0, running, alarm_flag}. Any write = dismiss.
  - 1 CONTROL: bit0 run, bit1 alarm_en, bit2 irq_en. Read back in [2:0].
  - 2 TIME_MS: [5:0] sec, [13:8] min.
  - 3 TIME_H: [4:0] hour.
  - 4 ALARM: [5:0] min, [12:8] hour.
  - 5 SNOOZE: read {state[1:0] at [15:14], remaining seconds [11:0]}. Any write = snooze request.
  - 6-7: read 0, writes ignored.
- Read latency: readdata is registered and updates every cycle from the address mux, so data is valid 1 cycle after address.
- Second advance:
  - Applies only when run=1.
  - Each tick increments the divider; when the divider reaches TICK_DIV-1 and tick=1, the divider clears and a second advance occurs. sec_pulse=1 on the following cycle.
  - Increment rule per field: if field >= max then 0 else field+1. Maxes are 59 sec, 59 min, 23 h.
  - Carry ripples in the same cycle, so 23:59:59 -> 00:00:00.
- Time writes:
  - Take priority over a same-cycle advance and clear the divider.
  - Out-of-range values (e.g. sec=63) are stored as written and wrap to 0 on the next advance.
- Alarm match: a second advance whose result equals alarm_h:alarm_m:00, with alarm_en=1.
- State machine (2-bit: IDLE=0, RINGING=1, SNOOZING=2):
  - IDLE -> RINGING on match. Sets alarm_flag and loads ring_cnt=RING_SECS.
  - RINGING, each advance: ring_cnt decrements. At 0 -> IDLE; alarm_flag stays set.
  - RINGING, SNOOZE write: -> SNOOZING, loads snz_cnt = SNOOZE_MIN*60.
  - RINGING, STATUS write: -> IDLE and clears alarm_flag.
  - SNOOZING, each advance: snz_cnt decrements. At 0 -> RINGING, sets alarm_flag, reloads ring_cnt.
  - SNOOZING, STATUS write: -> IDLE and clears flag.
  - SNOOZE write in IDLE or SNOOZING: ignored.
  - alarm_en=0 (written, or already 0) forces IDLE from any state; flag is unaffected.
  - run=0 freezes all counters, including ring_cnt and snz_cnt; the state is held.
- Outputs:
  - ring = (state==RINGING), registered.
  - irq = alarm_flag & irq_en, combinational from registers.
- Simultaneous events:
  - Match/reentry set of alarm_flag beats a same-cycle STATUS-write clear, and the state enters RINGING.
  - Reset mid-ring: returns to IDLE, ring=0 the next cycle.

Optional Feature:
- Macro: ALARM_RTC_BCD_EN.
- When defined:
  - TIME_MS, TIME_H and ALARM fields are read and written as packed BCD: sec [7:0], min [15:8], hour [7:0] / [15:8] in ALARM.
  - Internal counters stay binary, with binary<->BCD conversion at the register boundary.
  - An invalid BCD digit (>9) in a write is loaded as 0 for that field.
- When undefined: binary encoding exactly as in the register map.

Test Plan:
- Reset; write CONTROL=1, TIME_H=23, TIME_MS={59,59}; apply 1 tick -> TIME reads 00:00:00; sec_pulse=1 for one cycle.
- TICK_DIV=3, run=1, 6 ticks -> sec advances by exactly 2; time write on a tick cycle -> written value held, divider cleared.
- ALARM=07:30, time 07:29:59, CONTROL=7, 1 tick -> ring=1, irq=1, STATUS reads 0x0003; after RING_SECS=60 more ticks -> ring=0, irq still 1.
- While ringing, write SNOOZE -> ring=0, SNOOZE read shows state=2, remaining 300; 300 ticks -> ring=1, flag set.
- While ringing, write STATUS -> ring=0, irq=0, state IDLE; clearing alarm_en during SNOOZING -> IDLE, no re-ring.
- Assert reset while ringing -> next cycle ring=0, irq=0, readdata=0, time 00:00:00.

Source files
------------

// File: rtl/alarm_rtc.sv
// Alarm-clock RTC behind an Avalon-MM slave port, advanced by the interval timer's tick pulse.
// Define ALARM_RTC_BCD_EN for packed-BCD time/alarm registers (binary encoding otherwise).
module alarm_rtc #(
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        ring,
  output logic        sec_pulse
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_RINGING  = 2'd1;
  localparam logic [1:0]  ST_SNOOZING = 2'd2;
  localparam logic [7:0]  DIV_LAST    = 8'(TICK_DIV - 1);
  localparam logic [11:0] RING_LOAD   = 12'(RING_SECS);
  localparam logic [11:0] SNZ_LOAD    = 12'(SNOOZE_MIN * 60);

  logic [5:0]  sec_q, sec_d, min_q, min_d, al_min_q, al_min_d;
  logic [4:0]  hour_q, hour_d, al_hour_q, al_hour_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        flag_q, flag_d;
  logic [1:0]  state_q, state_d;
  logic [11:0] ring_cnt_q, ring_cnt_d, snz_cnt_q, snz_cnt_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] readdata_q, readdata_d;
  logic        ring_q, ring_d, sec_pulse_q, sec_pulse_d;

  logic wr, wr_status, wr_ctrl, wr_tms, wr_th, wr_alarm, wr_snooze, wr_time;
  logic div_hit, adv, en_next, match;
  logic sec_wrap, min_wrap, hour_wrap;
  logic [5:0]  wr_sec, wr_min, wr_al_min;
  logic [4:0]  wr_hour, wr_al_hour;
  logic [15:0] rd_tms, rd_th, rd_alarm;

  assign wr        = chipselect & ~write_n;
  assign wr_status = wr & (address == 3'd0);
  assign wr_ctrl   = wr & (address == 3'd1);
  assign wr_tms    = wr & (address == 3'd2);
  assign wr_th     = wr & (address == 3'd3);
  assign wr_alarm  = wr & (address == 3'd4);
  assign wr_snooze = wr & (address == 3'd5);
  assign wr_time   = wr_tms | wr_th;

`ifdef ALARM_RTC_BCD_EN
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, 4'(r)};
  endfunction

  // Any digit above 9 invalidates the whole field; legal values above the field width wrap.
  function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
    if ((b[7:4] > 4'd9) || (b[3:0] > 4'd9)) return 7'd0;
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  assign wr_sec     = 6'(bcd_to_bin(writedata[7:0]));
  assign wr_min     = 6'(bcd_to_bin(writedata[15:8]));
  assign wr_hour    = 5'(bcd_to_bin(writedata[7:0]));
  assign wr_al_min  = 6'(bcd_to_bin(writedata[7:0]));
  assign wr_al_hour = 5'(bcd_to_bin(writedata[15:8]));
  assign rd_tms     = {bin_to_bcd(min_q), bin_to_bcd(sec_q)};
  assign rd_th      = {8'd0, bin_to_bcd({1'b0, hour_q})};
  assign rd_alarm   = {bin_to_bcd({1'b0, al_hour_q}), bin_to_bcd(al_min_q)};
`else
  logic unused_wd;
  assign unused_wd  = ^{writedata[15:14], writedata[7:6]};
  assign wr_sec     = writedata[5:0];
  assign wr_min     = writedata[13:8];
  assign wr_hour    = writedata[4:0];
  assign wr_al_min  = writedata[5:0];
  assign wr_al_hour = writedata[12:8];
  assign rd_tms     = {2'b00, min_q, 2'b00, sec_q};
  assign rd_th      = {11'd0, hour_q};
  assign rd_alarm   = {3'd0, al_hour_q, 2'b00, al_min_q};
`endif

  // A time write owns the cycle: it suppresses any advance and restarts the divider.
  assign div_hit = tick & ctrl_q[0] & (div_q == DIV_LAST);
  assign adv     = div_hit & ~wr_time;

  always_comb begin
    div_d = div_q;
    if (wr_time) div_d = 8'd0;
    else if (ctrl_q[0] & tick) div_d = div_hit ? 8'd0 : div_q + 8'd1;
  end

  assign sec_wrap  = sec_q >= 6'd59;
  assign min_wrap  = min_q >= 6'd59;
  assign hour_wrap = hour_q >= 5'd23;

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (adv) begin
      sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
      if (sec_wrap) min_d = min_wrap ? 6'd0 : min_q + 6'd1;
      if (sec_wrap && min_wrap) hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
    end
    if (wr_tms) begin
      sec_d = wr_sec;
      min_d = wr_min;
    end
    if (wr_th) hour_d = wr_hour;
  end

  assign en_next = wr_ctrl ? writedata[1] : ctrl_q[1];
  assign match   = adv & en_next & (sec_d == 6'd0) & (min_d == al_min_q) & (hour_d == al_hour_q);

  // Alarm (re)entry into RINGING wins over a same-cycle dismiss.
  always_comb begin
    state_d    = state_q;
    flag_d     = flag_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!en_next) begin
      state_d = ST_IDLE;
      if (wr_status) flag_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match) begin
            state_d    = ST_RINGING;
            flag_d     = 1'b1;
            ring_cnt_d = RING_LOAD;
          end else if (wr_status) begin
            flag_d = 1'b0;
          end
        end
        ST_RINGING: begin
          if (wr_status) begin
            state_d = ST_IDLE;
            flag_d  = 1'b0;
          end else if (wr_snooze) begin
            state_d   = ST_SNOOZING;
            snz_cnt_d = SNZ_LOAD;
          end else if (adv) begin
            ring_cnt_d = ring_cnt_q - 12'd1;
            if (ring_cnt_q <= 12'd1) begin
              state_d    = ST_IDLE;
              ring_cnt_d = 12'd0;
            end
          end
        end
        ST_SNOOZING: begin
          if (adv) snz_cnt_d = snz_cnt_q - 12'd1;
          if (adv && (snz_cnt_q <= 12'd1)) begin
            state_d    = ST_RINGING;
            flag_d     = 1'b1;
            ring_cnt_d = RING_LOAD;
            snz_cnt_d  = 12'd0;
          end else if (wr_status) begin
            state_d = ST_IDLE;
            flag_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign ctrl_d    = wr_ctrl ? writedata[2:0] : ctrl_q;
  assign al_min_d  = wr_alarm ? wr_al_min : al_min_q;
  assign al_hour_d = wr_alarm ? wr_al_hour : al_hour_q;

  always_comb begin
    readdata_d = 16'd0;
    case (address)
      3'd0: readdata_d = {14'd0, ctrl_q[0], flag_q};
      3'd1: readdata_d = {13'd0, ctrl_q};
      3'd2: readdata_d = rd_tms;
      3'd3: readdata_d = rd_th;
      3'd4: readdata_d = rd_alarm;
      3'd5: readdata_d = {state_q, 2'b00, snz_cnt_q};
      default: readdata_d = 16'd0;
    endcase
  end

  assign ring_d      = (state_d == ST_RINGING);
  assign sec_pulse_d = adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hour_q      <= 5'd0;
      al_min_q    <= 6'd0;
      al_hour_q   <= 5'd0;
      ctrl_q      <= 3'd0;
      flag_q      <= 1'b0;
      state_q     <= ST_IDLE;
      ring_cnt_q  <= 12'd0;
      snz_cnt_q   <= 12'd0;
      div_q       <= 8'd0;
      readdata_q  <= 16'd0;
      ring_q      <= 1'b0;
      sec_pulse_q <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      al_min_q    <= al_min_d;
      al_hour_q   <= al_hour_d;
      ctrl_q      <= ctrl_d;
      flag_q      <= flag_d;
      state_q     <= state_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
      div_q       <= div_d;
      readdata_q  <= readdata_d;
      ring_q      <= ring_d;
      sec_pulse_q <= sec_pulse_d;
    end
  end

  assign readdata  = readdata_q;
  assign ring      = ring_q;
  assign sec_pulse = sec_pulse_q;
  assign irq       = flag_q & ctrl_q[2];

endmodule

// File: tb/tb_alarm_rtc.sv
// Scoreboard bench for alarm_rtc: two instances (tick divider 1 and 3) share stimulus and
// are checked against an integer field-level reference model.
module tb_alarm_rtc;

  localparam int RS  = 60;
  localparam int SNZ = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata, readdata3;
  logic        irq, ring, sec_pulse, irq3, ring3, sec_pulse3;

  always #5 clk = ~clk;

  alarm_rtc #(.TICK_DIV(1), .RING_SECS(RS), .SNOOZE_MIN(5)) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .ring(ring), .sec_pulse(sec_pulse));

  alarm_rtc #(.TICK_DIV(3), .RING_SECS(RS), .SNOOZE_MIN(5)) u_div3 (
    .clk(clk), .reset(reset), .tick(tick), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata3), .irq(irq3),
    .ring(ring3), .sec_pulse(sec_pulse3));

  // reference model, index 0 = divider 1, index 1 = divider 3
  int sec[2], mn[2], hr[2], am[2], ah[2], ctrl[2], flag[2], st[2], rc[2], sc[2], dv[2];
  int pulses[2];

  typedef struct {
    string nm;
    int    rd0, rd1;
    bit    rg0, rg1, iq0, iq1;
    int    np0, np1;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int seen0 = 0;
  int seen1 = 0;
  logic rd_valid = 1'b0;

  function automatic int td(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int rdval(input int k, input int a);
    case (a)
      0: return ((ctrl[k] & 1) << 1) | flag[k];
      1: return ctrl[k];
      2: return (mn[k] << 8) | sec[k];
      3: return hr[k];
      4: return (ah[k] << 8) | am[k];
      5: return (st[k] << 14) | sc[k];
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sec[k] = 0; mn[k] = 0; hr[k] = 0; am[k] = 0; ah[k] = 0; ctrl[k] = 0;
      flag[k] = 0; st[k] = 0; rc[k] = 0; sc[k] = 0; dv[k] = 0;
    end
  endtask

  // state codes: 0 idle, 1 ringing, 2 snoozing
  task automatic model_step(input int k, input bit tk, input bit cs, input bit wn,
                            input int a, input int d);
    bit wr, adv, en, match, stw, snw;
    wr  = cs && !wn;
    adv = 0;
    if (wr && (a == 2 || a == 3)) begin
      if (a == 2) begin
        sec[k] = d & 63;
        mn[k]  = (d >> 8) & 63;
      end else begin
        hr[k] = d & 31;
      end
      dv[k] = 0;
    end else if ((ctrl[k] & 1) != 0 && tk) begin
      if (dv[k] == td(k) - 1) begin
        dv[k] = 0;
        adv = 1;
      end else begin
        dv[k]++;
      end
    end
    if (adv) begin
      if (sec[k] >= 59) begin
        sec[k] = 0;
        if (mn[k] >= 59) begin
          mn[k] = 0;
          hr[k] = (hr[k] >= 23) ? 0 : hr[k] + 1;
        end else begin
          mn[k]++;
        end
      end else begin
        sec[k]++;
      end
      pulses[k]++;
    end
    en    = (wr && a == 1) ? (((d >> 1) & 1) != 0) : (((ctrl[k] >> 1) & 1) != 0);
    match = adv && en && sec[k] == 0 && mn[k] == am[k] && hr[k] == ah[k];
    stw   = wr && a == 0;
    snw   = wr && a == 5;
    if (!en) begin
      st[k] = 0;
      if (stw) flag[k] = 0;
    end else if (st[k] == 0) begin
      if (match) begin
        st[k] = 1; flag[k] = 1; rc[k] = RS;
      end else if (stw) begin
        flag[k] = 0;
      end
    end else if (st[k] == 1) begin
      if (stw) begin
        st[k] = 0; flag[k] = 0;
      end else if (snw) begin
        st[k] = 2; sc[k] = SNZ;
      end else if (adv) begin
        rc[k]--;
        if (rc[k] == 0) st[k] = 0;
      end
    end else begin
      if (adv) sc[k]--;
      if (adv && sc[k] == 0) begin
        st[k] = 1; flag[k] = 1; rc[k] = RS;
      end else if (stw) begin
        st[k] = 0; flag[k] = 0;
      end
    end
    if (wr && a == 1) ctrl[k] = d & 7;
    if (wr && a == 4) begin
      am[k] = d & 63;
      ah[k] = (d >> 8) & 31;
    end
  endtask

  task automatic cyc(input string nm, input bit tk, input bit cs, input bit wn,
                     input int a, input int d);
    exp_t e;
    bit chk_it;
    chk_it = cs && wn;
    e.nm  = nm;
    e.rd0 = rdval(0, a);
    e.rd1 = rdval(1, a);
    tick = tk; chipselect = cs; write_n = wn; address = a[2:0]; writedata = d[15:0];
    @(posedge clk);
    #1;
    model_step(0, tk, cs, wn, a, d);
    model_step(1, tk, cs, wn, a, d);
    if (chk_it) begin
      e.rg0 = (st[0] == 1); e.rg1 = (st[1] == 1);
      e.iq0 = (flag[0] != 0) && ((ctrl[0] & 4) != 0);
      e.iq1 = (flag[1] != 0) && ((ctrl[1] & 4) != 0);
      e.np0 = pulses[0]; e.np1 = pulses[1];
      q.push_back(e);
    end
    tick = 1'b0; chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr_reg(input int a, input int d);
    cyc("wr", 1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd_reg(input string nm, input int a);
    cyc(nm, 1'b0, 1'b1, 1'b1, a, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc("tk", 1'b1, 1'b0, 1'b1, 0, 0);
  endtask

  task automatic rst_chk(input string nm);
    exp_t e;
    reset = 1'b1; chipselect = 1'b1; write_n = 1'b1; address = 3'd2; tick = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; chipselect = 1'b0;
    model_reset();
    e.nm = nm; e.rd0 = 0; e.rd1 = 0; e.rg0 = 0; e.rg1 = 0; e.iq0 = 0; e.iq1 = 0;
    e.np0 = pulses[0]; e.np1 = pulses[1];
    q.push_back(e);
  endtask

  task automatic arm(input int h, input int m);
    wr_reg(4, (h << 8) | m);
    wr_reg(3, h);
    wr_reg(2, ((m - 1) << 8) | 59);
    wr_reg(1, 7);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, req);
    end
  endtask

  always @(posedge clk) rd_valid <= chipselect & write_n;

  always @(negedge clk) begin
    exp_t e;
    if (sec_pulse)  seen0++;
    if (sec_pulse3) seen1++;
    if (rd_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: readdata presented with no expected entry queued");
      end else begin
        e = q.pop_front();
        chk({e.nm, "_rd"},     int'(readdata),  e.rd0);
        chk({e.nm, "_rd3"},    int'(readdata3), e.rd1);
        chk({e.nm, "_ring"},   int'(ring),      int'(e.rg0));
        chk({e.nm, "_ring3"},  int'(ring3),     int'(e.rg1));
        chk({e.nm, "_irq"},    int'(irq),       int'(e.iq0));
        chk({e.nm, "_irq3"},   int'(irq3),      int'(e.iq1));
        chk({e.nm, "_pulses"}, seen0,           e.np0);
        chk({e.nm, "_pulses3"}, seen1,          e.np1);
      end
    end
  end

  initial begin
    int r, a, d;
    pulses[0] = 0; pulses[1] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_chk("reset");
    rd_reg("reset_status", 0);

    // midnight rollover
    wr_reg(1, 1); wr_reg(3, 23); wr_reg(2, (59 << 8) | 59);
    ticks(1);
    rd_reg("roll_ms", 2);
    rd_reg("roll_h", 3);

    // divider, and a time write landing on a tick
    wr_reg(2, 0); wr_reg(3, 0);
    ticks(6);
    rd_reg("div_ms", 2);
    ticks(2);
    cyc("tw_on_tick", 1'b1, 1'b1, 1'b0, 2, (10 << 8) | 11);
    rd_reg("tw_held", 2);
    ticks(2);
    rd_reg("tw_div_clr", 2);
    ticks(1);
    rd_reg("tw_adv", 2);

    // alarm match and auto-stop
    arm(7, 30);
    ticks(1);
    rd_reg("match_status", 0);
    ticks(RS);
    rd_reg("autostop_status", 0);
    wr_reg(0, 0);
    rd_reg("dismiss_idle", 0);

    // snooze and re-ring
    rst_chk("reset2");
    arm(7, 30);
    ticks(1);
    wr_reg(5, 0);
    rd_reg("snooze_rd", 5);
    ticks(SNZ - 1);
    rd_reg("snooze_early", 5);
    ticks(1);
    rd_reg("reentry", 0);

    // dismiss while ringing, then alarm_en off during snooze
    wr_reg(0, 1);
    rd_reg("dismiss", 5);
    arm(8, 15);
    ticks(1);
    wr_reg(5, 0);
    wr_reg(1, 5);
    rd_reg("en_off", 5);
    ticks(SNZ + 20);
    rd_reg("no_rering", 0);

    // reset mid-ring
    arm(9, 1);
    ticks(1);
    rd_reg("pre_reset", 0);
    rst_chk("reset_ring");
    rd_reg("post_reset_ms", 2);
    rd_reg("post_reset_st", 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 600 == 0) arm($urandom_range(0, 23), $urandom_range(1, 59));
      r = $urandom_range(0, 99);
      a = $urandom_range(0, 7);
      if (r < 6) begin
        d = int'($urandom);
        if (a == 1 && $urandom_range(0, 3) != 0) d = d | 3;
        cyc("rnd_wr", 1'($urandom_range(0, 1)), 1'b1, 1'b0, a, d);
      end else if (r < 40) begin
        cyc("rnd_rd", 1'($urandom_range(0, 1)), 1'b1, 1'b1, a, 0);
      end else begin
        cyc("rnd_idle", 1'($urandom_range(0, 1)), 1'b0, 1'b1, 0, 0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
